// File: rtl/universal_latch_register_if.sv
// Bus bundle for universal_latch_register: control, data and status signals.
// The clock and the clear line stay as plain ports on the register itself.
interface universal_latch_register_if #(
    parameter int WIDTH = 8
);
    logic             preset;
    logic             enable;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             serial_in;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             carry_out;
    logic             zero;

    modport master (
        output preset, enable, mode, d, serial_in,
        input  q, q_bar, carry_out, zero
    );

    modport slave (
        input  preset, enable, mode, d, serial_in,
        output q, q_bar, carry_out, zero
    );
endinterface

// File: rtl/universal_latch_register.sv
// General-purpose datapath register: load, shift, rotate and (optionally) count.
// Define UNIVERSAL_LATCH_REGISTER_COUNT_EN to enable increment/decrement modes 110/111.
module universal_latch_register #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic                          clk,
    input  logic                          clear,
    universal_latch_register_if.slave     bus
);
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_t;

    logic [WIDTH-1:0] q_r, q_next;
    logic             carry_r, carry_next;
    mode_t            mode_sel;

    assign mode_sel = mode_t'(bus.mode);

`ifdef UNIVERSAL_LATCH_REGISTER_COUNT_EN
    // One extra bit on each side gives the carry/borrow for free.
    logic [WIDTH:0] inc_sum, dec_diff;
    assign inc_sum  = {1'b0, q_r} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_diff = {1'b0, q_r} - {{WIDTH{1'b0}}, 1'b1};
`endif

    always_comb begin
        q_next     = q_r;
        carry_next = carry_r;
        if (!bus.preset) begin
            q_next     = PRESET_VALUE;
            carry_next = 1'b0;
        end else if (bus.enable) begin
            case (mode_sel)
                MODE_LOAD: begin
                    q_next     = bus.d;
                    carry_next = 1'b0;
                end
                MODE_SHL: begin
                    q_next     = {q_r[WIDTH-2:0], bus.serial_in};
                    carry_next = q_r[WIDTH-1];
                end
                MODE_SHR: begin
                    q_next     = {bus.serial_in, q_r[WIDTH-1:1]};
                    carry_next = q_r[0];
                end
                MODE_ROL: begin
                    q_next     = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                    carry_next = q_r[WIDTH-1];
                end
                MODE_ROR: begin
                    q_next     = {q_r[0], q_r[WIDTH-1:1]};
                    carry_next = q_r[0];
                end
`ifdef UNIVERSAL_LATCH_REGISTER_COUNT_EN
                MODE_INC: begin
                    q_next     = inc_sum[WIDTH-1:0];
                    carry_next = inc_sum[WIDTH];
                end
                MODE_DEC: begin
                    q_next     = dec_diff[WIDTH-1:0];
                    carry_next = dec_diff[WIDTH];
                end
`endif
                default: begin
                    q_next     = q_r;
                    carry_next = carry_r;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q_r     <= RESET_VALUE;
            carry_r <= 1'b0;
        end else begin
            q_r     <= q_next;
            carry_r <= carry_next;
        end
    end

    assign bus.q         = q_r;
    assign bus.q_bar     = ~q_r;
    assign bus.carry_out = carry_r;
    assign bus.zero      = (q_r == {WIDTH{1'b0}});
endmodule

// File: tb/tb_universal_latch_register.sv
// Directed bench for universal_latch_register: vector table plus hand-written
// sequences for asynchronous clear, preset priority and the count modes.
module tb_universal_latch_register;
    logic clk;
    logic clear;
    int   n_cmp;
    int   n_fail;

    universal_latch_register_if #(.WIDTH(8)) bus ();

    universal_latch_register #(.WIDTH(8)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       preset;
        logic       enable;
        logic [2:0] mode;
        logic [7:0] d;
        logic       serial_in;
        logic [7:0] exp_q;
        logic       exp_c;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [7:0] eq, input logic ec);
        logic [7:0] eqb;
        logic       ez;
        eqb = ~eq;
        ez  = (eq == 8'h00);
        n_cmp++;
        if (bus.q !== eq || bus.q_bar !== eqb || bus.zero !== ez || bus.carry_out !== ec) begin
            n_fail++;
            $display("FAIL %s: got q=%h q_bar=%h zero=%b carry=%b, need q=%h q_bar=%h zero=%b carry=%b",
                     name, bus.q, bus.q_bar, bus.zero, bus.carry_out, eq, eqb, ez, ec);
        end
    endtask

    task automatic drive(input logic p, input logic e, input logic [2:0] m,
                         input logic [7:0] dv, input logic si);
        bus.preset    = p;
        bus.enable    = e;
        bus.mode      = m;
        bus.d         = dv;
        bus.serial_in = si;
    endtask

    task automatic step(input logic p, input logic e, input logic [2:0] m,
                        input logic [7:0] dv, input logic si);
        drive(p, e, m, dv, si);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        //            pre en  mode    d      si    q      c
        vecs[0]  = '{1'b1, 1'b1, 3'b001, 8'h5A, 1'b0, 8'h5A, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'b001, 8'h12, 1'b0, 8'hFF, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 3'b001, 8'h12, 1'b0, 8'h12, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 3'b001, 8'h81, 1'b0, 8'h81, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 8'h02, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 3'b101, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'b011, 8'h00, 1'b1, 8'h80, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 8'h01, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 3'b000, 8'hEE, 1'b1, 8'h01, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 3'b010, 8'h00, 1'b1, 8'h03, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'b001, 8'h3C, 1'b0, 8'h3C, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'b001, 8'hAA, 1'b0, 8'h3C, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'b001, 8'hAA, 1'b0, 8'h3C, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 3'b001, 8'hAA, 1'b0, 8'h3C, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 3'b001, 8'hAA, 1'b0, 8'hAA, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 3'b011, 8'h00, 1'b0, 8'h55, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 3'b101, 8'h00, 1'b0, 8'hAA, 1'b1};

        // Reset state, observed while clear is still held low.
        clear = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0);
        #2;
        check("reset_state", 8'h00, 1'b0);
        @(negedge clk);
        clear = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].preset, vecs[i].enable, vecs[i].mode, vecs[i].d, vecs[i].serial_in);
            check($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_c);
        end

        // Asynchronous clear mid-cycle from q=5A with carry set.
        step(1'b1, 1'b1, 3'b001, 8'hAD, 1'b0);
        step(1'b1, 1'b1, 3'b010, 8'h00, 1'b0);
        check("pre_clear", 8'h5A, 1'b1);
        drive(1'b1, 1'b1, 3'b001, 8'h77, 1'b0);
        #2;
        clear = 1'b0;
        #1;
        check("async_clear", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("clear_held", 8'h00, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clear_release", 8'h77, 1'b0);

        // Count modes across the wrap boundaries.
        step(1'b1, 1'b1, 3'b001, 8'hFE, 1'b0);
        step(1'b1, 1'b1, 3'b110, 8'h00, 1'b0);
`ifdef UNIVERSAL_LATCH_REGISTER_COUNT_EN
        check("inc_to_ff", 8'hFF, 1'b0);
`else
        check("inc_hold1", 8'hFE, 1'b0);
`endif
        step(1'b1, 1'b1, 3'b110, 8'h00, 1'b0);
`ifdef UNIVERSAL_LATCH_REGISTER_COUNT_EN
        check("inc_wrap", 8'h00, 1'b1);
`else
        check("inc_hold2", 8'hFE, 1'b0);
`endif
        step(1'b1, 1'b1, 3'b111, 8'h00, 1'b0);
`ifdef UNIVERSAL_LATCH_REGISTER_COUNT_EN
        check("dec_wrap", 8'hFF, 1'b1);
`else
        check("dec_hold", 8'hFE, 1'b0);
`endif

        // Count modes from q=33 with carry set.
        step(1'b1, 1'b1, 3'b001, 8'h67, 1'b0);
        step(1'b1, 1'b1, 3'b011, 8'h00, 1'b0);
        check("setup_33", 8'h33, 1'b1);
        step(1'b1, 1'b1, 3'b110, 8'h00, 1'b1);
`ifdef UNIVERSAL_LATCH_REGISTER_COUNT_EN
        check("inc_33", 8'h34, 1'b0);
`else
        check("hold_110", 8'h33, 1'b1);
`endif
        step(1'b1, 1'b1, 3'b111, 8'h00, 1'b1);
`ifdef UNIVERSAL_LATCH_REGISTER_COUNT_EN
        check("dec_34", 8'h33, 1'b0);
`else
        check("hold_111", 8'h33, 1'b1);
`endif

        // Preset wins over a disabled register too.
        step(1'b0, 1'b0, 3'b001, 8'h00, 1'b0);
        check("preset_disabled", 8'hFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/universal_latch_register.md
Name: universal_latch_register

Overview:
- Parametrised WIDTH-bit edge-triggered register; next generation of the gated SR storage element.
- Adds parallel load, shift, rotate and count modes, a registered carry/shift-out flag and a zero flag.
- Serves as the general-purpose datapath register in the 8-bit computer: A/B registers, shift register and program-counter-style counting.

Parameters:
WIDTH, 8, number of storage bits (minimum 2).
RESET_VALUE, {WIDTH{1'b0}}, value loaded by asynchronous clear.
PRESET_VALUE, {WIDTH{1'b1}}, value loaded by synchronous preset.

Ports:
clk  input  1  rising-edge clock.
clear  input  1  asynchronous active-low reset.
preset  input  1  synchronous active-low preset.
enable  input  1  active-high operation enable.
mode  input  3  operation select; encoding in Behaviour.
d  input  WIDTH  parallel load data.
serial_in  input  1  bit shifted into the vacated position.
q  output  WIDTH  register contents.
q_bar  output  WIDTH  always ~q.
carry_out  output  1  registered shift-out, carry or borrow flag.
zero  output  1  combinational, 1 when q == 0.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, on port clear.
- clear=0, at any time, independent of clk: q=RESET_VALUE and carry_out=0 immediately; held while low. Release is synchronous-safe, and the first update happens on the next rising clk edge with clear=1.
- Priority at each rising clk edge with clear=1:
  - preset=0: q=PRESET_VALUE, carry_out=0.
  - Else enable=0: q and carry_out hold.
  - Else mode executes.
- Mode encoding (registered; new q visible one cycle after the edge):
  - 000 hold: q and carry_out unchanged.
  - 001 load: q=d, carry_out=0.
  - 010 shift left: q={q[W-2:0],serial_in}, carry_out=old q[W-1].
  - 011 shift right: q={serial_in,q[W-1:1]}, carry_out=old q[0].
  - 100 rotate left: q={q[W-2:0],q[W-1]}, carry_out=old q[W-1]; serial_in ignored.
  - 101 rotate right: q={q[0],q[W-1:1]}, carry_out=old q[0].
  - 110 increment: q=q+1 mod 2^W; carry_out=1 iff old q was all-ones (wraps to 0).
  - 111 decrement: q=q-1 mod 2^W; carry_out=1 iff old q was 0 (borrow, wraps to all-ones).
- Outputs:
  - q_bar and zero are combinational from q; no extra latency.
  - During clear=0, q_bar=~RESET_VALUE and zero reflects RESET_VALUE.
- Simultaneous events:
  - clear overrides everything.
  - preset overrides enable and mode.
  - Unknown or X on mode while enable=1 is a verification error; RTL behaviour for X is unconstrained.
- Reset mid-operation: clear asserted between edges aborts any sequence; no partial update survives.
- Arithmetic is unsigned, WIDTH bits, no saturation.

Optional Feature:
UNIVERSAL_LATCH_REGISTER_COUNT_EN
- Defined: modes 110 and 111 increment and decrement as specified.
- Undefined:
  - Modes 110 and 111 behave as hold (q and carry_out unchanged).
  - No adder or subtractor is synthesised.
  - All other modes are identical.

Test Plan:
- clear=0 mid-cycle with q=8'h5A -> q=8'h00, q_bar=8'hFF, zero=1, carry_out=0 without waiting for a clk edge.
- preset=0, enable=1, mode=001, d=8'h12 at one edge -> q=8'hFF (preset wins), carry_out=0; next edge with preset=1 -> q=8'h12.
- q=8'h81, mode=010, serial_in=0 -> q=8'h02, carry_out=1; then mode=101 -> q=8'h01, carry_out=0; then mode=011, serial_in=1 -> q=8'h80, carry_out=1.
- COUNT_EN defined, q=8'hFE, mode=110 for 2 edges -> 8'hFF (carry_out=0), then 8'h00 (carry_out=1, zero=1); mode=111 -> q=8'hFF, carry_out=1.
- COUNT_EN undefined, q=8'h33, carry_out=1, mode=110 then 111 -> q stays 8'h33, carry_out stays 1.
- enable=0 with mode=001, d=8'hAA for 3 edges -> q unchanged from prior 8'h3C; enable=1 next edge -> q=8'hAA.
